// File: rtl/fetch_pc_unit_if.sv
// Bundle between the fetch PC generator and its neighbours (hazard unit,
// prediction unit, ID-stage comparator and decoder, I-memory, IF/ID register).
interface fetch_pc_unit_if #(
  parameter int CNT_W = 16
) ();
  logic             stall;
  logic [31:0]      instr_if;
  logic             BrPre;
  logic             PreWrong;
  logic             jr_en;
  logic [31:0]      jr_target;
  logic [31:0]      pc_if;
  logic [31:0]      pc_plus4_if;
  logic             flush_if;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;
  // Recovery-register state, exported for debug and checkers.
  logic [31:0]      alt_pc_id;
  logic             br_valid_id;

  modport master (
    input  stall, instr_if, BrPre, PreWrong, jr_en, jr_target,
    output pc_if, pc_plus4_if, flush_if, br_cnt, miss_cnt, alt_pc_id, br_valid_id
  );

  modport slave (
    output stall, instr_if, BrPre, PreWrong, jr_en, jr_target,
    input  pc_if, pc_plus4_if, flush_if, br_cnt, miss_cnt, alt_pc_id, br_valid_id
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Next-PC selection for the IF stage with one-cycle mispredict recovery
// and saturating branch/mispredict counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  fetch_pc_unit_if.master  bus
);

  // Flow contract: there is no valid/ready pair. stall=1 freezes every
  // register and suppresses redirects and flushes; otherwise every cycle
  // the inputs describe the instruction at pc_if and the branch in ID.

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      alt_pc_q, alt_pc_d;
  logic             br_valid_q, br_valid_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic        is_br;
  logic        is_j;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        recover;
  logic        flush;

  assign pc_plus4 = pc_q + 32'd4;
  assign opcode   = bus.instr_if[31:26];
  assign is_br    = (opcode == 6'h04) || (opcode == 6'h05);
  assign is_j     = (opcode == 6'h02) || (opcode == 6'h03);
  assign br_off   = {{14{bus.instr_if[15]}}, bus.instr_if[15:0], 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_plus4[31:28], bus.instr_if[25:0], 2'b00};

  // A PreWrong with no tracked branch in ID is spurious and ignored.
  assign recover = bus.PreWrong && br_valid_q;
  assign flush   = rst_n && !bus.stall && (recover || bus.jr_en);

  always_comb begin
    pc_d       = pc_q;
    alt_pc_d   = alt_pc_q;
    br_valid_d = br_valid_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (!bus.stall) begin
      if (recover) begin
        pc_d = alt_pc_q;
      end else if (bus.jr_en) begin
        pc_d = bus.jr_target;
      end else if (is_j) begin
        pc_d = j_tgt;
      end else if (is_br && bus.BrPre) begin
        pc_d = br_tgt;
      end else begin
        pc_d = pc_plus4;
      end
      // Remember the path not taken; a flushed branch is never tracked.
      br_valid_d = is_br && !flush;
      alt_pc_d   = bus.BrPre ? pc_plus4 : br_tgt;
      if (br_valid_q && !(&br_cnt_q)) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (recover && !(&miss_cnt_q)) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      alt_pc_q   <= 32'h0000_0000;
      br_valid_q <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      alt_pc_q   <= alt_pc_d;
      br_valid_q <= br_valid_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.pc_if       = pc_q;
  assign bus.pc_plus4_if = pc_plus4;
  assign bus.flush_if    = flush;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.alt_pc_id   = alt_pc_q;
  assign bus.br_valid_id = br_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a CNT_W=16 and a CNT_W=2 instance share
// the same stimulus; the narrow one exposes counter saturation.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BEQ3 = 32'h1000_0003;  // beq, imm +3
  localparam logic [31:0] BNEM = 32'h1400_FFFE;  // bne, imm -2
  localparam logic [31:0] J40  = 32'h0800_0040;  // j, target field 0x40

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] instr;
  logic        brpre;
  logic        prewrong;
  logic        jr_en;
  logic [31:0] jr_target;

  int n_checks;
  int n_pass;

  fetch_pc_unit_if #(.CNT_W(16)) ifa ();
  fetch_pc_unit_if #(.CNT_W(2))  ifb ();

  assign ifa.stall     = stall;
  assign ifa.instr_if  = instr;
  assign ifa.BrPre     = brpre;
  assign ifa.PreWrong  = prewrong;
  assign ifa.jr_en     = jr_en;
  assign ifa.jr_target = jr_target;
  assign ifb.stall     = stall;
  assign ifb.instr_if  = instr;
  assign ifb.BrPre     = brpre;
  assign ifb.PreWrong  = prewrong;
  assign ifb.jr_en     = jr_en;
  assign ifb.jr_target = jr_target;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: apply one cycle of inputs just after the posedge.
  task automatic set_in(input logic [31:0] i, input logic bp, input logic pw,
                        input logic jr, input logic [31:0] jt, input logic st);
    instr     = i;
    brpre     = bp;
    prewrong  = pw;
    jr_en     = jr;
    jr_target = jt;
    stall     = st;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    set_in(NOP, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    next_cycle();
    next_cycle();
    check("rst_flush", {31'd0, ifa.flush_if}, 32'd0);
    check("rst_pc", ifa.pc_if, 32'h0);
    check("rst_alt", ifa.alt_pc_id, 32'h0);
    check("rst_valid", {31'd0, ifa.br_valid_id}, 32'd0);
    check("rst_brcnt", {16'd0, ifa.br_cnt}, 32'd0);
    check("rst_misscnt", {16'd0, ifa.miss_cnt}, 32'd0);
    rst_n = 1'b1;

    // Sequential NOPs
    for (int k = 0; k < 4; k++) begin
      set_in(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("seq_pc", ifa.pc_if, 32'(4 * k));
      check("seq_pc4", ifa.pc_plus4_if, 32'(4 * k + 4));
      check("seq_flush", {31'd0, ifa.flush_if}, 32'd0);
      next_cycle();
    end

    // beq not predicted, then mispredicted
    set_in(BEQ3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("beq_pc", ifa.pc_if, 32'h10);
    next_cycle();
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("beq_fall_pc", ifa.pc_if, 32'h14);
    check("beq_alt", ifa.alt_pc_id, 32'h20);
    check("beq_flush", {31'd0, ifa.flush_if}, 32'd1);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    check("beq_rec_pc", ifa.pc_if, 32'h20);
    check("beq_brcnt", {16'd0, ifa.br_cnt}, 32'd1);
    check("beq_misscnt", {16'd0, ifa.miss_cnt}, 32'd1);
    check("jr_flush", {31'd0, ifa.flush_if}, 32'd1);
    next_cycle();

    // bne predicted taken backward, then mispredicted
    set_in(BNEM, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("bne_pc", ifa.pc_if, 32'h40);
    check("bne_flush", {31'd0, ifa.flush_if}, 32'd0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bne_tgt_pc", ifa.pc_if, 32'h3C);
    check("bne_alt", ifa.alt_pc_id, 32'h44);
    check("bne_flush_miss", {31'd0, ifa.flush_if}, 32'd1);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    check("bne_rec_pc", ifa.pc_if, 32'h44);
    check("bne_misscnt", {16'd0, ifa.miss_cnt}, 32'd2);
    next_cycle();

    // Same branch, prediction correct
    set_in(BNEM, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("bne_ok_pc", ifa.pc_if, 32'h3C);
    check("bne_ok_flush", {31'd0, ifa.flush_if}, 32'd0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b1, 32'h1000_0080, 1'b0);
    check("bne_ok_cont", ifa.pc_if, 32'h40);
    check("bne_ok_brcnt", {16'd0, ifa.br_cnt}, 32'd3);
    check("bne_ok_misscnt", {16'd0, ifa.miss_cnt}, 32'd2);
    next_cycle();

    // j then jr
    set_in(J40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("j_pc", ifa.pc_if, 32'h1000_0080);
    check("j_flush", {31'd0, ifa.flush_if}, 32'd0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    check("j_tgt_pc", ifa.pc_if, 32'h1000_0100);
    check("jr_flush2", {31'd0, ifa.flush_if}, 32'd1);
    next_cycle();

    // Stall with valid branch in ID and PreWrong asserted
    set_in(BEQ3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("jr_tgt_pc", ifa.pc_if, 32'h200);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check("stall_pc", ifa.pc_if, 32'h204);
      check("stall_alt", ifa.alt_pc_id, 32'h210);
      check("stall_valid", {31'd0, ifa.br_valid_id}, 32'd1);
      check("stall_flush", {31'd0, ifa.flush_if}, 32'd0);
      check("stall_brcnt", {16'd0, ifa.br_cnt}, 32'd3);
      check("stall_misscnt", {16'd0, ifa.miss_cnt}, 32'd2);
      next_cycle();
    end
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("release_flush", {31'd0, ifa.flush_if}, 32'd1);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("release_pc", ifa.pc_if, 32'h210);
    check("release_brcnt", {16'd0, ifa.br_cnt}, 32'd4);
    check("release_misscnt", {16'd0, ifa.miss_cnt}, 32'd3);
    check("spur_valid", {31'd0, ifa.br_valid_id}, 32'd0);
    next_cycle();

    // Spurious PreWrong with no branch in ID
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("spur_flush", {31'd0, ifa.flush_if}, 32'd0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("spur_pc", ifa.pc_if, 32'h218);
    check("spur_misscnt", {16'd0, ifa.miss_cnt}, 32'd3);

    // Saturation: fresh reset, then six mispredicted beqs
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_in(BEQ3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("sat_br_pc", ifa.pc_if, 32'(16 * k));
      next_cycle();
      // A predicted-taken beq in IF loses to recovery and is flushed
      set_in(BEQ3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("sat_flush", {31'd0, ifa.flush_if}, 32'd1);
      next_cycle();
      if (k == 4) begin
        check("sat5_brcnt_w2", {30'd0, ifb.br_cnt}, 32'd3);
        check("sat5_misscnt_w2", {30'd0, ifb.miss_cnt}, 32'd3);
        check("sat5_brcnt_w16", {16'd0, ifa.br_cnt}, 32'd5);
        check("sat5_misscnt_w16", {16'd0, ifa.miss_cnt}, 32'd5);
      end
    end
    check("sat_pc", ifa.pc_if, 32'h60);
    check("sat_hold_brcnt_w2", {30'd0, ifb.br_cnt}, 32'd3);
    check("sat_hold_misscnt_w2", {30'd0, ifb.miss_cnt}, 32'd3);
    check("sat_misscnt_w16", {16'd0, ifa.miss_cnt}, 32'd6);

    // Reset mid-stream with a branch in ID and PreWrong pending
    set_in(BEQ3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst_flush", {31'd0, ifa.flush_if}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_in(NOP, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst_pc", ifa.pc_if, 32'h0);
    check("midrst_valid", {31'd0, ifa.br_valid_id}, 32'd0);
    check("midrst_nofl", {31'd0, ifa.flush_if}, 32'd0);
    check("midrst_brcnt_w2", {30'd0, ifb.br_cnt}, 32'd0);
    check("midrst_misscnt_w2", {30'd0, ifb.miss_cnt}, 32'd0);
    check("midrst_brcnt_w16", {16'd0, ifa.br_cnt}, 32'd0);
    next_cycle();
    set_in(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_seq_pc", ifa.pc_if, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch PC generator for the 5-stage MIPS pipeline; directly upstream of the branch prediction unit and the ID-stage branch comparator.
- Each cycle it selects the next PC from five sources: sequential, predicted branch target, jump, jr, or misprediction recovery.
- It keeps the not-chosen ("alternate") PC of the branch now in ID, so that a PreWrong from the comparator redirects fetch in one cycle.
- It also keeps saturating branch and mispredict counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  pipeline freeze from the hazard unit or a cache miss.
- instr_if  in  32  instruction fetched at pc_if this cycle.
- BrPre  in  1  prediction for instr_if (1 = taken), from the prediction unit.
- PreWrong  in  1  misprediction flag for the branch in ID, from the comparator.
- jr_en  in  1  jr/jalr decoded in ID.
- jr_target  in  32  register target for jr, from ID.
- pc_if  out  32  current fetch PC, sent to I-memory.
- pc_plus4_if  out  32  pc_if + 4, sent to the IF/ID register.
- flush_if  out  1  kill the instruction currently in IF (write a bubble into IF/ID).
- br_cnt  out  CNT_W  number of conditional branches that resolved in ID.
- miss_cnt  out  CNT_W  number of mispredictions.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - pc_if = RESET_PC.
  - alt_pc_id = 0, br_valid_id = 0.
  - br_cnt = 0, miss_cnt = 0.
  - flush_if = 0 while rst_n = 0.
  - Reset mid-operation discards any pending recovery.
- IF decode (combinational, from instr_if[31:26]):
  - is_br = opcode 6'h04 or 6'h05.
  - is_j = opcode 6'h02 or 6'h03.
- Address arithmetic (all 32-bit, wrap modulo 2^32, no overflow flag):
  - br_tgt = pc_plus4_if + (sign_extend(instr_if[15:0]) << 2).
  - j_tgt = {pc_plus4_if[31:28], instr_if[25:0], 2'b00}.
- Next-PC priority, evaluated only when stall=0:
  1. PreWrong && br_valid_id -> alt_pc_id.
  2. jr_en -> jr_target.
  3. is_j -> j_tgt.
  4. is_br && BrPre -> br_tgt.
  5. otherwise pc_plus4_if.
- flush_if = !stall && ((PreWrong && br_valid_id) || jr_en).
  - The jump in IF does not flush: its delay-free redirect simply fetches the target next cycle.
- Recovery register (ID-aligned), updated on every non-stalled cycle:
  - br_valid_id <= is_br && !flush_if.
  - alt_pc_id <= BrPre ? pc_plus4_if : br_tgt.
  - A branch that is itself flushed is not tracked.
- PreWrong while br_valid_id=0 (no branch in ID) is ignored. It causes no redirect, no flush and no count.
- stall=1: pc_if, alt_pc_id, br_valid_id and the counters all hold. PreWrong and jr_en are ignored and flush_if = 0. This matches the prediction unit, which also holds its state on stall.
- Counters, updated on non-stalled cycles:
  - br_cnt increments when br_valid_id=1.
  - miss_cnt increments when br_valid_id && PreWrong.
  - Both saturate at all-ones; no wrap.
- Latency:
  - A redirect takes effect on pc_if at the first posedge after the selecting cycle.
  - Mispredict penalty is exactly one bubble (one flushed IF slot).
- Simultaneous events:
  - PreWrong (valid) with a jump or predicted branch in IF: recovery wins and the IF instruction is flushed.
  - PreWrong with jr_en cannot both be legitimate; recovery wins.

Test Plan:
- Reset, then 3 non-stalled cycles of NOPs -> pc_if = 0, 4, 8, 12; flush_if = 0; counters 0.
- At pc 0x10, beq with imm 0x0003 and BrPre=0; next cycle PreWrong=1 -> pc_if sequence 0x10, 0x14, 0x20. flush_if=1 in the cycle pc_if=0x14. br_cnt=1, miss_cnt=1.
- At pc 0x40, bne with imm 0xFFFE and BrPre=1 -> next pc_if = 0x3C. Next cycle PreWrong=1 -> pc_if = 0x44. Same branch with PreWrong=0 -> continues at 0x40, miss_cnt unchanged.
- j at pc 0x1000_0080 with target field 0x0000_040 -> next pc_if = 0x1000_0100, flush_if=0. jr_en=1 with jr_target=0x200 -> next pc_if = 0x200, flush_if=1.
- Stall held 3 cycles with PreWrong=1 and a valid branch in ID -> pc_if, counters and alt_pc_id unchanged. On release with PreWrong=1 -> redirect to alt_pc_id.
- Preset counters near saturation via a CNT_W=2 instance, then run 5 mispredicted branches -> br_cnt = miss_cnt = 3, held. Assert rst_n=0 mid-stream -> next cycle pc_if = RESET_PC and both counters 0.
